// File: rtl/mano_timing_pkg.sv
// Shared timing constants and run-state encoding for the control unit.
package mano_timing_pkg;

    localparam int unsigned SC_WIDTH   = 3;
    localparam int unsigned T_LAST     = 6;
    localparam int unsigned ICNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear dominates; increment stops once the count reaches all-ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sequence_counter.sv
// Timing-sequence counter: run state, SC clear/hold/increment policy,
// instruction accounting and the sticky T-state overrun flag.
module sequence_counter #(
    parameter int unsigned SC_WIDTH   = mano_timing_pkg::SC_WIDTH,
    parameter int unsigned T_LAST     = mano_timing_pkg::T_LAST,
    parameter int unsigned ICNT_WIDTH = mano_timing_pkg::ICNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hlt,
    input  logic                  sc_clr,
    input  logic                  sc_hold,
    output logic [SC_WIDTH-1:0]   sc_value,
    output logic                  running,
    output logic                  wrap,
    output logic                  t_overrun,
    output logic [ICNT_WIDTH-1:0] instr_count
);

    import mano_timing_pkg::*;

    localparam logic [SC_WIDTH-1:0] T_LAST_SC = SC_WIDTH'(T_LAST);

    state_t              state, state_n;
    logic [SC_WIDTH-1:0] sc_n;
    logic                wrap_n;
    logic                ovr_n;
    logic                count_en;

    // State, SC and flag registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sc_value  <= '0;
            running   <= 1'b0;
            wrap      <= 1'b0;
            t_overrun <= 1'b0;
        end else begin
            state     <= state_n;
            sc_value  <= sc_n;
            running   <= (state_n == RUN);
            wrap      <= wrap_n;
            t_overrun <= ovr_n;
        end
    end

    // Next-state and SC policy: in RUN the order is hlt > sc_clr > sc_hold > increment.
    always_comb begin
        state_n  = state;
        sc_n     = sc_value;
        wrap_n   = 1'b0;
        ovr_n    = t_overrun;
        count_en = 1'b0;
        unique case (state)
            IDLE, HALTED: begin
                sc_n = '0;
                if (start) begin
                    state_n = RUN;
                    ovr_n   = 1'b0;
                end
            end
            RUN: begin
                if (hlt) begin
                    sc_n     = '0;
                    count_en = 1'b1;
                    state_n  = HALTED;
                end else if (sc_clr) begin
                    sc_n     = '0;
                    count_en = 1'b1;
                end else if (!sc_hold) begin
                    sc_n = sc_value + 1'b1;
                    if (sc_value == T_LAST_SC) begin
                        ovr_n = 1'b1;
                    end
                    if (sc_value == '1) begin
                        wrap_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                sc_n    = '0;
            end
        endcase
    end

    sat_counter #(
        .WIDTH(ICNT_WIDTH)
    ) u_icnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (count_en),
        .count(instr_count)
    );

endmodule
